inst_fetch_buf: RTL and testbench

- Parametrised instruction-fetch stage for the openMIPS pipeline. Generalises the fixed 6-bit-PC fetch with a parametrised PC width and reset vector.
- Adds four features: a synchronous 1-cycle-latency instruction memory interface, a prefetch FIFO, a decode-side valid/ready handshake, and branch redirect with flush.
- Sits between the instruction ROM/cache and the IF/ID boundary. Delivers (pc, instruction) pairs in program order.

---
 rtl/inst_fetch_buf.sv | 138 +++++++++++++
 tb/tb_inst_fetch_buf.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buf.sv
// Instruction fetch stage: 1-cycle synchronous memory, prefetch FIFO, valid/ready output, redirect.
// Optional IFETCH_ALIGN_CHK_EN: a misaligned redirect halts fetch and raises exc_misalign_o.
module inst_fetch_buf #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int unsigned       DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o,
`ifdef IFETCH_ALIGN_CHK_EN
  output logic              exc_misalign_o,
`endif
  input  logic              ready_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthOcc = (CntW+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] tag_q;
  logic              inflight_q;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [31:0]       inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic [CntW:0]     occ;
  logic              halted;
  logic              issue;
  logic              push;
  logic              pop;
  logic [31:0]       push_inst;
  logic [ADDR_W-1:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc_i[ADDR_W-1:2], 2'b00};

`ifdef IFETCH_ALIGN_CHK_EN
  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e state_q;
  logic   pend_q;
  logic   exc_mem [DEPTH];
  logic   misalign;

  assign misalign  = |redirect_pc_i[1:0];
  assign halted    = (state_q == StHalt);
  // The pending exception entry reuses the tag register for the unmodified target.
  assign push_inst = pend_q ? '0 : mem_rdata;
  assign push      = (inflight_q | pend_q) & ~redirect_i;
  assign exc_misalign_o = valid_o ? exc_mem[rd_ptr_q] : 1'b0;
`else
  logic unused_rpc_low;

  assign unused_rpc_low = ^redirect_pc_i[1:0];
  assign halted    = 1'b0;
  assign push_inst = mem_rdata;
  assign push      = inflight_q & ~redirect_i;
`endif

  // Same-cycle pops are deliberately not credited, so occupancy alone gates issue.
  assign occ      = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign issue    = rstn & ~redirect_i & ~halted & (occ < DepthOcc);
  assign mem_ce   = issue;
  assign mem_addr = rstn ? pc_q : '0;

  assign valid_o  = (count_q != '0);
  assign pop      = valid_o & ready_i & ~redirect_i;
  assign inst_o   = valid_o ? inst_mem[rd_ptr_q] : '0;
  assign pc_o     = valid_o ? pc_mem[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= push_inst;
      pc_mem[wr_ptr_q]   <= tag_q;
`ifdef IFETCH_ALIGN_CHK_EN
      exc_mem[wr_ptr_q]  <= pend_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= PC_RESET;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef IFETCH_ALIGN_CHK_EN
      state_q    <= StRun;
      pend_q     <= 1'b0;
`endif
    end else if (redirect_i) begin
      pc_q       <= redirect_tgt;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef IFETCH_ALIGN_CHK_EN
      if (misalign) begin
        state_q <= StHalt;
        pend_q  <= 1'b1;
        tag_q   <= redirect_pc_i;
      end else begin
        state_q <= StRun;
        pend_q  <= 1'b0;
      end
`endif
    end else begin
      if (issue) begin
        pc_q  <= pc_q + ADDR_W'(4);
        tag_q <= pc_q;
      end
      inflight_q <= issue;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
`ifdef IFETCH_ALIGN_CHK_EN
      pend_q <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf: a 32-bit instance for the main flow plus an 8-bit one for PC wrap.
module tb_inst_fetch_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        rstn, mem_ce, redirect, ready, valid;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, inst, pc;
`ifdef IFETCH_ALIGN_CHK_EN
  logic        exc;
`endif

  logic        rstn8, mem_ce8, redirect8, ready8, valid8;
  logic [7:0]  mem_addr8, redirect_pc8, pc8;
  logic [31:0] mem_rdata8, inst8;
`ifdef IFETCH_ALIGN_CHK_EN
  logic        exc8;
`endif

  inst_fetch_buf #(.ADDR_W(32), .PC_RESET(32'h100), .DEPTH(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .mem_ce       (mem_ce),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .inst_o       (inst),
    .pc_o         (pc),
    .valid_o      (valid),
`ifdef IFETCH_ALIGN_CHK_EN
    .exc_misalign_o(exc),
`endif
    .ready_i      (ready)
  );

  inst_fetch_buf #(.ADDR_W(8), .PC_RESET(8'hF8), .DEPTH(4)) dut8 (
    .clk          (clk),
    .rstn         (rstn8),
    .mem_ce       (mem_ce8),
    .mem_addr     (mem_addr8),
    .mem_rdata    (mem_rdata8),
    .redirect_i   (redirect8),
    .redirect_pc_i(redirect_pc8),
    .inst_o       (inst8),
    .pc_o         (pc8),
    .valid_o      (valid8),
`ifdef IFETCH_ALIGN_CHK_EN
    .exc_misalign_o(exc8),
`endif
    .ready_i      (ready8)
  );

  // ROM models: the word returned is the byte address it was read from.
  always @(posedge clk) if (mem_ce)  mem_rdata  <= mem_addr;
  always @(posedge clk) if (mem_ce8) mem_rdata8 <= {24'h0, mem_addr8};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic [31:0] p);
    chk({tag, ".valid"}, 32'(valid), 32'd1);
    chk({tag, ".pc"}, pc, p);
    chk({tag, ".inst"}, inst, p);
  endtask

  task automatic head8(input string tag, input logic [7:0] p);
    chk({tag, ".valid"}, 32'(valid8), 32'd1);
    chk({tag, ".pc"}, 32'(pc8), 32'(p));
    chk({tag, ".inst"}, inst8, 32'(p));
  endtask

  initial begin
    rstn = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
    rstn8 = 1'b0; redirect8 = 1'b0; redirect_pc8 = '0; ready8 = 1'b1;
    cyc(); cyc(); #1;
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.mem_ce", 32'(mem_ce), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.inst", inst, 32'd0);
    chk("rst.pc", pc, 32'd0);
    chk("rst8.mem_ce", 32'(mem_ce8), 32'd0);

    // Release mid-cycle: this cycle issues PC_RESET, head appears two cycles later.
    rstn = 1'b1; #1;
    chk("c0.mem_ce", 32'(mem_ce), 32'd1);
    chk("c0.mem_addr", mem_addr, 32'h100);
    cyc(); #1; chk("c1.valid", 32'(valid), 32'd0);
    cyc(); #1; head("c2", 32'h100);
    cyc(); #1; head("c3", 32'h104);
    cyc(); ready = 1'b0; #1; head("c4", 32'h108);

    // Stall: FIFO fills (108,10C,110,114) and fetch stops after one more issue.
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      head("stall", 32'h108);
      chk("stall.mem_ce", 32'(mem_ce), 32'(i == 0));
    end
    cyc(); ready = 1'b1; #1; head("drain0", 32'h108);
    for (int i = 1; i < 7; i++) begin
      cyc(); #1;
      head("drain", 32'(32'h108 + 4 * i));
    end

    // One stalled cycle leaves 3 entries plus a read in flight, then redirect with a pop.
    cyc(); ready = 1'b0; #1; head("pre_rd", 32'h124);
    cyc(); ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h2000; #1;
    chk("rd_t.mem_ce", 32'(mem_ce), 32'd0);
    cyc(); redirect = 1'b0; #1;
    chk("rd_t1.valid", 32'(valid), 32'd0);
    chk("rd_t1.mem_ce", 32'(mem_ce), 32'd1);
    chk("rd_t1.mem_addr", mem_addr, 32'h2000);
    cyc(); #1; chk("rd_t2.valid", 32'(valid), 32'd0);
    cyc(); #1; head("rd_t3", 32'h2000);
    cyc(); #1; head("rd_t4", 32'h2004);
    cyc(); #1; head("rd_t5", 32'h2008);

    // Back-to-back redirects: the second target wins.
    cyc(); redirect = 1'b1; redirect_pc = 32'h3000; #1;
    chk("b2b0.mem_ce", 32'(mem_ce), 32'd0);
`ifdef IFETCH_ALIGN_CHK_EN
    cyc(); redirect_pc = 32'h4004; #1;
`else
    cyc(); redirect_pc = 32'h4007; #1;
`endif
    chk("b2b1.mem_ce", 32'(mem_ce), 32'd0);
    cyc(); redirect = 1'b0; #1;
    chk("b2b2.valid", 32'(valid), 32'd0);
    chk("b2b2.mem_ce", 32'(mem_ce), 32'd1);
    chk("b2b2.mem_addr", mem_addr, 32'h4004);
    cyc(); #1; chk("b2b3.valid", 32'(valid), 32'd0);
    cyc(); #1; head("b2b4", 32'h4004);
    cyc(); #1; head("b2b5", 32'h4008);

    // Asynchronous reset between edges.
    cyc(); #2; rstn = 1'b0; #1;
    chk("arst.valid", 32'(valid), 32'd0);
    chk("arst.mem_ce", 32'(mem_ce), 32'd0);
    chk("arst.pc", pc, 32'd0);
    cyc(); #1; chk("arst1.valid", 32'(valid), 32'd0);
    rstn = 1'b1; #1;
    chk("rel.mem_ce", 32'(mem_ce), 32'd1);
    chk("rel.mem_addr", mem_addr, 32'h100);
    cyc(); #1; chk("rel1.valid", 32'(valid), 32'd0);
    cyc(); #1; head("rel2", 32'h100);
    cyc(); #1; head("rel3", 32'h104);

    // 8-bit PC wraps from FC to 00.
    rstn8 = 1'b1; #1;
    chk("w0.mem_ce", 32'(mem_ce8), 32'd1);
    chk("w0.mem_addr", 32'(mem_addr8), 32'hF8);
    cyc(); #1; chk("w1.valid", 32'(valid8), 32'd0);
    cyc(); #1; head8("w2", 8'hF8);
    cyc(); #1; head8("w3", 8'hFC);
    cyc(); #1; head8("w4", 8'h00);
    cyc(); #1; head8("w5", 8'h04);

`ifdef IFETCH_ALIGN_CHK_EN
    // Misaligned redirect: single NOP entry flagged, then halt until an aligned redirect.
    cyc(); redirect = 1'b1; redirect_pc = 32'h2002; #1;
    chk("mis_t.mem_ce", 32'(mem_ce), 32'd0);
    cyc(); redirect = 1'b0; #1;
    chk("mis_t1.mem_ce", 32'(mem_ce), 32'd0);
    chk("mis_t1.valid", 32'(valid), 32'd0);
    cyc(); #1;
    chk("mis_t2.valid", 32'(valid), 32'd1);
    chk("mis_t2.inst", inst, 32'd0);
    chk("mis_t2.pc", pc, 32'h2002);
    chk("mis_t2.exc", 32'(exc), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("halt.valid", 32'(valid), 32'd0);
      chk("halt.mem_ce", 32'(mem_ce), 32'd0);
      chk("halt.exc", 32'(exc), 32'd0);
    end
    cyc(); redirect = 1'b1; redirect_pc = 32'h3000; #1;
    cyc(); redirect = 1'b0; #1;
    chk("resume.mem_ce", 32'(mem_ce), 32'd1);
    chk("resume.mem_addr", mem_addr, 32'h3000);
    cyc(); cyc(); #1;
    head("resume", 32'h3000);
    chk("resume.exc", 32'(exc), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
